module_div_result_bcd: RTL and testbench

// - Downstream stage of the division unit. Accepts quotient + divide-by-zero error

---
 rtl/div_bcd_pkg.sv | 9 +
 rtl/module_bcd_add3.sv | 11 +
 rtl/module_div_result_bcd.sv | 141 ++++++++++++++
 tb/tb_module_div_result_bcd.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/div_bcd_pkg.sv
// rtl/div_bcd_pkg.sv - shared state encoding and digit codes for the BCD result stage
package div_bcd_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} div_bcd_state_t;

    localparam logic [3:0] BCD_ERR   = 4'hE;
    localparam logic [3:0] BCD_BLANK = 4'hF;

endpackage

// File: rtl/module_bcd_add3.sv
// rtl/module_bcd_add3.sv - double-dabble digit correction (d >= 5 ? d + 3 : d)
module module_bcd_add3 (
    input  logic [3:0] d,
    output logic [3:0] q
);

    always_comb begin
        q = (d >= 4'd5) ? (d + 4'd3) : d;
    end

endmodule

// File: rtl/module_div_result_bcd.sv
// rtl/module_div_result_bcd.sv - divider quotient to packed BCD, one bit per cycle
// Optional leading-zero blanking: define DIV_BCD_BLANK_EN.
module module_div_result_bcd
    import div_bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [WIDTH-1:0]      i_quotient,
    input  logic                  i_error,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic                  o_error
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    if (10**DIGITS <= 2**WIDTH - 1) begin : g_digits_check
        $error("DIGITS too small to hold the largest WIDTH-bit quotient");
    end

    div_bcd_state_t          state;
    div_bcd_state_t          state_n;
    logic [WIDTH-1:0]        bin_q;
    logic [BCD_W-1:0]        bcd_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [BCD_W-1:0]        corr;
    logic [BCD_W+WIDTH-1:0]  shift_w;
    logic [BCD_W-1:0]        final_bcd;
    logic                    accept;
    logic                    last_shift;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        module_bcd_add3 u_add3 (
            .d (bcd_q[4*g +: 4]),
            .q (corr[4*g +: 4])
        );
    end

    // Correct digits first, then shift the combined {bcd,bin} register left by one.
    assign shift_w    = {corr, bin_q} << 1;
    assign accept     = i_valid && o_ready;
    assign last_shift = (state == SHIFT) && (cnt_q == CNT_W'(WIDTH - 1));

`ifdef DIV_BCD_BLANK_EN
    function automatic logic [BCD_W-1:0] blank_leading(input logic [BCD_W-1:0] v);
        logic lead;
        blank_leading = v;
        lead = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (lead && (v[4*i +: 4] == 4'd0)) begin
                blank_leading[4*i +: 4] = BCD_BLANK;
            end else begin
                lead = 1'b0;
            end
        end
    endfunction

    assign final_bcd = blank_leading(shift_w[BCD_W+WIDTH-1:WIDTH]);
`else
    assign final_bcd = shift_w[BCD_W+WIDTH-1:WIDTH];
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = i_error ? HOLD : SHIFT;
                end
            end
            SHIFT: begin
                if (last_shift) begin
                    state_n = HOLD;
                end
            end
            HOLD: begin
                if (i_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        o_ready = (state == IDLE);
        o_valid = (state == HOLD);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            o_bcd   <= '0;
            o_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        o_error <= i_error;
                        if (i_error) begin
                            o_bcd <= {DIGITS{BCD_ERR}};
                        end else begin
                            bin_q <= i_quotient;
                            bcd_q <= '0;
                            cnt_q <= '0;
                        end
                    end
                end
                SHIFT: begin
                    bcd_q <= shift_w[BCD_W+WIDTH-1:WIDTH];
                    bin_q <= shift_w[WIDTH-1:0];
                    if (last_shift) begin
                        cnt_q <= '0;
                        o_bcd <= final_bcd;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_module_div_result_bcd.sv
// tb/tb_module_div_result_bcd.sv - scoreboard bench with decimal reference model
module tb_module_div_result_bcd;

    typedef struct {
        logic [11:0] bcd;
        logic        err;
        int          edges;
        int          acc_cyc;
    } item_t;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [7:0]  i_quotient = '0;
    logic        i_error = 1'b0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [11:0] o_bcd;
    logic        o_error;

    item_t       sb[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          rand_ready = 0;
    bit          prev_valid = 0;
    bit          prev_hs = 0;
    logic [11:0] prev_bcd = '0;
    logic        prev_err = 1'b0;

    module_div_result_bcd #(.WIDTH(8), .DIGITS(3)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_quotient (i_quotient),
        .i_error    (i_error),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_bcd      (o_bcd),
        .o_error    (o_error)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [11:0] ref_bcd(input int q, input bit err);
        logic [3:0]  d0, d1, d2;
        logic [11:0] r;
        if (err) return 12'hEEE;
        d0 = 4'(q % 10);
        d1 = 4'((q / 10) % 10);
        d2 = 4'(q / 100);
        r = {d2, d1, d0};
`ifdef DIV_BCD_BLANK_EN
        if (q < 100) r[11:8] = 4'hF;
        if (q < 10)  r[7:4]  = 4'hF;
`endif
        return r;
    endfunction

    always @(posedge i_clk) begin
        if (rand_ready) begin
            #2 i_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compares each newly presented result and checks stability while stalled.
    always @(negedge i_clk) begin
        item_t it;
        if (!i_rst_n) begin
            prev_valid = 0;
            prev_hs = 0;
        end else begin
            if (o_valid && (!prev_valid || prev_hs)) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", 32'(o_valid), 32'd0);
                end else begin
                    it = sb.pop_front();
                    check("bcd", 32'(o_bcd), 32'(it.bcd));
                    check("error", 32'(o_error), 32'(it.err));
                    check("latency", 32'(cyc - it.acc_cyc), 32'(it.edges));
                end
            end else if (o_valid) begin
                check("hold_bcd_stable", 32'(o_bcd), 32'(prev_bcd));
                check("hold_err_stable", 32'(o_error), 32'(prev_err));
            end
            prev_valid = o_valid;
            prev_hs    = o_valid && i_ready;
            prev_bcd   = o_bcd;
            prev_err   = o_error;
        end
    end

    task automatic send(input logic [7:0] q, input logic e);
        int    w;
        item_t it;
        w = 0;
        @(negedge i_clk);
        while (!o_ready && w < 300) begin
            @(negedge i_clk);
            w++;
        end
        if (!o_ready) begin
            check("ready_timeout", 32'(o_ready), 32'd1);
            return;
        end
        i_valid = 1'b1;
        i_quotient = q;
        i_error = e;
        @(posedge i_clk);
        #1;
        it.bcd = ref_bcd(int'(q), e);
        it.err = e;
        it.edges = e ? 0 : 8;
        it.acc_cyc = cyc;
        sb.push_back(it);
        i_valid = 1'b0;
        i_quotient = 8'($urandom);
        i_error = 1'($urandom);
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while ((sb.size() != 0 || o_valid) && w < 500) begin
            @(negedge i_clk);
            w++;
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic [11:0] held;
        int          w;
        repeat (3) @(negedge i_clk);
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_bcd", 32'(o_bcd), 32'd0);
        i_rst_n = 1'b1;

        // Reset mid-conversion: nothing is pushed, so any o_valid would be flagged.
        @(negedge i_clk);
        i_valid = 1'b1;
        i_quotient = 8'd200;
        i_error = 1'b0;
        @(posedge i_clk);
        #1 i_valid = 1'b0;
        repeat (3) @(posedge i_clk);
        #1 i_rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(o_valid), 32'd0);
        check("midrst_bcd", 32'(o_bcd), 32'd0);
        check("midrst_error", 32'(o_error), 32'd0);
        check("midrst_ready", 32'(o_ready), 32'd1);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (12) @(negedge i_clk);
        check("midrst_no_valid", 32'(o_valid), 32'd0);

        send(8'd255, 1'b0);
        send(8'd0, 1'b0);
        send(8'd100, 1'b0);
        send(8'd37, 1'b1);
        send(8'd9, 1'b0);
        send(8'd42, 1'b0);
        send(8'd5, 1'b0);
        wait_drain();

        // Backpressure with ignored i_valid pulses.
        i_ready = 1'b0;
        send(8'd123, 1'b0);
        w = 0;
        while (!o_valid && w < 50) begin
            @(negedge i_clk);
            w++;
        end
        check("bp_valid_seen", 32'(o_valid), 32'd1);
        held = o_bcd;
        for (int k = 0; k < 5; k++) begin
            i_valid = 1'b1;
            i_quotient = 8'($urandom);
            i_error = 1'($urandom);
            @(negedge i_clk);
            check("bp_ready_low", 32'(o_ready), 32'd0);
            check("bp_bcd_held", 32'(o_bcd), 32'(held));
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge i_clk);
        check("bp_release_valid", 32'(o_valid), 32'd0);
        check("bp_release_ready", 32'(o_ready), 32'd1);
        check("bp_release_bcd", 32'(o_bcd), 32'(held));
        wait_drain();

        rand_ready = 1;
        for (int n = 0; n < 40; n++) begin
            send(8'($urandom), ($urandom_range(0, 7) == 0));
        end
        rand_ready = 0;
        #3 i_ready = 1'b1;
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
